// File: rtl/sad_accum_core.sv
// sad_accum_core: streaming 4-lane sum-of-absolute-differences accumulator with length check and saturation
module sad_accum_core #(
  parameter int C_LEN_W = 24,
  parameter int C_ACC_W = 32
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cfg_start,
  input  logic [C_LEN_W-1:0] cfg_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data_a,
  input  logic [31:0]        s_data_b,
  input  logic               s_last,
  output logic [C_ACC_W-1:0] sad_result,
  output logic               busy,
  output logic               done,
  output logic               err_len,
  output logic               ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [C_LEN_W-1:0] len, cnt, cnt_nx;
  logic [3:0][7:0] ad, d1;
  logic [9:0] sum, s2;
  logic v1, v2;
  logic [C_ACC_W-1:0] acc;
  logic [C_ACC_W:0] acc_sum;
  logic err_q, ovf_q, start, xfer;
  assign start = cfg_start & (state == IDLE | state == DONE);
  assign xfer = s_valid & s_ready;
  assign cnt_nx = cnt + C_LEN_W'(1);
  assign sum = 10'(d1[0]) + 10'(d1[1]) + 10'(d1[2]) + 10'(d1[3]);
  assign acc_sum = (C_ACC_W+1)'(acc) + (C_ACC_W+1)'(s2);
  assign s_ready = state == RUN;
  assign busy = state == RUN | state == DRAIN;
  assign done = state == DONE;
  assign sad_result = acc;
  assign err_len = err_q;
  assign ovf = ovf_q;
  always_comb begin
    ad = '0;
    for (int i = 0; i < 4; i++)
      ad[i] = s_data_a[8*i+:8] > s_data_b[8*i+:8] ? s_data_a[8*i+:8] - s_data_b[8*i+:8]
                                                  : s_data_b[8*i+:8] - s_data_a[8*i+:8];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? (cfg_len == '0 ? DONE : RUN) : state;
      RUN:        state_nx = xfer && (s_last || cnt_nx == len) ? DRAIN : RUN;
      DRAIN:      state_nx = !v1 && !v2 ? DONE : DRAIN;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      len <= '0;
      cnt <= '0;
      d1 <= '0;
      s2 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      acc <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      v1 <= xfer;
      v2 <= v1;
      if (xfer) d1 <= ad;
      if (v1) s2 <= sum;
      if (start) begin
        len <= cfg_len;
        cnt <= '0;
        acc <= '0;
        err_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        // an early s_last or a missing s_last on the final counted beat both flag a length error
        if (xfer) begin
          cnt <= cnt_nx;
          if (s_last ? cnt_nx != len : cnt_nx == len) err_q <= 1'b1;
        end
        if (v2) begin
          acc <= acc_sum[C_ACC_W] ? '1 : acc_sum[C_ACC_W-1:0];
          if (acc_sum[C_ACC_W]) ovf_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sad_accum_core.sv
// tb_sad_accum_core: directed and randomized runs checked against a beat-list reference model
module tb_sad_accum_core;
  logic ACLK = 1'b0, ARESETN = 1'b0, cfg_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [23:0] cfg_len = '0;
  logic [31:0] s_data_a = '0, s_data_b = '0;
  logic s_ready, busy, done, err_len, ovf;
  logic [31:0] sad_result;
  logic s_ready12, busy12, done12, err12, ovf12;
  logic [11:0] sad12;
  int nvec = 0, nerr = 0;
  logic [31:0] pa[$], pb[$];
  bit pl[$];

  always #5 ACLK = ~ACLK;

  sad_accum_core dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_a(s_data_a), .s_data_b(s_data_b),
    .s_last(s_last), .sad_result(sad_result), .busy(busy), .done(done),
    .err_len(err_len), .ovf(ovf));

  sad_accum_core #(.C_ACC_W(12)) dut12 (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .s_valid(s_valid), .s_ready(s_ready12), .s_data_a(s_data_a), .s_data_b(s_data_b),
    .s_last(s_last), .sad_result(sad12), .busy(busy12), .done(done12),
    .err_len(err12), .ovf(ovf12));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int beat_sad(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      int x = int'(a[8*i+:8]);
      int y = int'(b[8*i+:8]);
      s += x > y ? x - y : y - x;
    end
    return s;
  endfunction

  // beats are consumed until the first s_last or until len beats, whichever comes first
  task automatic model(input int len, output int cons, output longint tot, output bit err);
    cons = 0; tot = 0; err = 1'b0;
    for (int i = 0; i < pa.size() && len > 0; i++) begin
      cons++;
      tot += beat_sad(pa[i], pb[i]);
      if (pl[i] || cons == len) begin
        err = cons != len || !pl[i];
        break;
      end
    end
  endtask

  task automatic fill(input int n, input int last_at, input bit rnd, input logic [31:0] a, input logic [31:0] b);
    pa.delete(); pb.delete(); pl.delete();
    for (int i = 1; i <= n; i++) begin
      pa.push_back(rnd ? $urandom : a);
      pb.push_back(rnd ? $urandom : b);
      pl.push_back(i == last_at);
    end
  endtask

  task automatic do_run(input string tag, input int len, input bit gap, input bit poke);
    int cons, idx = 0, cyc = 0, k = 0;
    longint tot;
    bit err;
    model(len, cons, tot, err);
    @(posedge ACLK); #1;
    cfg_start = 1'b1; cfg_len = 24'(len);
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    while (s_ready && cyc < 200) begin
      s_valid = idx < pa.size() && (!gap || cyc % 2 == 0);
      s_data_a = idx < pa.size() ? pa[idx] : '0;
      s_data_b = idx < pa.size() ? pb[idx] : '0;
      s_last = idx < pa.size() ? pl[idx] : 1'b0;
      cfg_start = poke && cyc == 1;
      cfg_len = poke ? 24'd9 : 24'(len);
      @(posedge ACLK); #1;
      cyc++;
      if (s_valid) idx++;
    end
    s_valid = 1'b0; s_last = 1'b0; cfg_start = 1'b0;
    while (!done && k < 20) begin
      @(posedge ACLK); #1;
      k++;
    end
    chk({tag, " beats"}, 64'(idx), 64'(cons));
    chk({tag, " latency"}, 64'(k), len == 0 ? 64'd0 : 64'd3);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " sad"}, 64'(sad_result), 64'(tot));
    chk({tag, " err_len"}, 64'(err_len), 64'(err));
    chk({tag, " ovf"}, 64'(ovf), 64'd0);
    chk({tag, " sad12"}, 64'(sad12), tot > 4095 ? 64'd4095 : 64'(tot));
    chk({tag, " ovf12"}, 64'(ovf12), 64'(tot > 4095));
  endtask

  initial begin
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst s_ready", 64'(s_ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err_len", 64'(err_len), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    chk("rst sad", 64'(sad_result), 64'd0);
    @(negedge ACLK) ARESETN = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("idle wait busy", 64'(busy), 64'd0);
    chk("idle wait ready", 64'(s_ready), 64'd0);

    fill(1, 1, 1'b0, 32'h01020304, 32'h04030201);
    do_run("single", 1, 1'b0, 1'b0);
    chk("single sad8", 64'(sad_result), 64'd8);
    fill(4, 4, 1'b0, 32'hFFFFFFFF, 32'h0);
    do_run("gapped", 4, 1'b1, 1'b0);
    chk("gapped sad4080", 64'(sad_result), 64'd4080);
    fill(4, 2, 1'b1, '0, '0);
    do_run("early_last", 4, 1'b0, 1'b0);
    chk("early_last err", 64'(err_len), 64'd1);
    fill(2, 0, 1'b1, '0, '0);
    do_run("no_last", 2, 1'b0, 1'b0);
    chk("no_last err", 64'(err_len), 64'd1);
    fill(0, 0, 1'b0, '0, '0);
    do_run("zero_len", 0, 1'b0, 1'b0);
    fill(5, 5, 1'b0, 32'hFFFFFFFF, 32'h0);
    do_run("saturate", 5, 1'b0, 1'b0);
    chk("saturate sad12 fff", 64'(sad12), 64'hFFF);
    chk("saturate ovf12 set", 64'(ovf12), 64'd1);
    fill(6, 6, 1'b1, '0, '0);
    do_run("start_in_run", 6, 1'b0, 1'b1);

    @(posedge ACLK); #1;
    cfg_start = 1'b1; cfg_len = 24'd4;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    s_valid = 1'b1; s_data_a = 32'hFFFFFFFF; s_data_b = 32'h0;
    repeat (2) begin
      @(posedge ACLK); #1;
    end
    s_valid = 1'b0;
    ARESETN = 1'b0;
    #1;
    chk("midrst s_ready", 64'(s_ready), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst sad", 64'(sad_result), 64'd0);
    repeat (3) @(posedge ACLK);
    #1;
    chk("midrst sad held", 64'(sad_result), 64'd0);
    chk("midrst sad12 held", 64'(sad12), 64'd0);
    @(negedge ACLK) ARESETN = 1'b1;
    fill(3, 3, 1'b1, '0, '0);
    do_run("after_rst", 3, 1'b0, 1'b0);

    for (int r = 0; r < 16; r++) begin
      int len = $urandom_range(1, 8);
      int mode = $urandom_range(0, 3);
      int last_at = mode == 0 ? $urandom_range(1, len) : mode == 1 ? 0 : len;
      fill(len, last_at, 1'b1, '0, '0);
      do_run($sformatf("rand%0d", r), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sad_accum_core.md
SAD_ACCUM_CORE -- requirements
Module: sad_accum_core

Interface
Parameters:
REQ-001 C_LEN_W, 24, width of the beat-count configuration.
REQ-002 C_ACC_W, 32, width of the SAD accumulator and result.

Ports:
REQ-003 ACLK  input  1  Single clock; all logic is rising-edge ACLK.
REQ-004 ARESETN  input  1  Reset, asynchronous, active-low.
REQ-005 cfg_start  input  1  One-cycle start pulse from the AXI4-Lite register bank.
REQ-006 cfg_len  input  C_LEN_W  Number of beats to process; sampled on an accepted start.
REQ-007 s_valid  input  1  Pixel beat valid.
REQ-008 s_ready  output  1  Pixel beat ready.
REQ-009 s_data_a  input  32  Four 8-bit unsigned pixels of block A, lane i = bits [8i+7:8i].
REQ-010 s_data_b  input  32  Four 8-bit unsigned pixels of block B, same lane mapping.
REQ-011 s_last  input  1  Marks the final beat of a block.
REQ-012 sad_result  output  C_ACC_W  Accumulated sum of absolute differences, stable while done=1.
REQ-013 busy  output  1  High in RUN and DRAIN.
REQ-014 done  output  1  High in DONE; held until the next accepted start.
REQ-015 err_len  output  1  s_last position did not match cfg_len in the last run.
REQ-016 ovf  output  1  Accumulator saturated in the last run.

Function
REQ-017 FSM states are IDLE, RUN, DRAIN and DONE; reset state is IDLE.
REQ-018 cfg_start is accepted only in IDLE or DONE; it is ignored in RUN and DRAIN.
REQ-019 An accepted start does all of the following in one action:
- latches cfg_len;
- clears the accumulator, beat counter, err_len and ovf;
- deasserts done;
- enters RUN, or enters DONE on the next cycle with sad_result=0 when cfg_len=0.
REQ-020 s_ready = 1 only in RUN; a beat transfers when s_valid and s_ready are both high.
REQ-021 Pipeline stage 1 registers the four 8-bit |a_i - b_i| values.
REQ-022 Pipeline stage 2 registers their 10-bit sum.
REQ-023 Pipeline stage 3 adds that sum into the accumulator.
REQ-024 Each stage carries a valid bit, and the pipeline never stalls.
REQ-025 The accumulator saturates at 2^C_ACC_W-1; the first saturating add sets ovf, which stays set (sticky) until the next accepted start.
REQ-026 The beat counter increments on each transfer; RUN exits to DRAIN on the transfer where counter+1 = latched length.
REQ-027 Early s_last (transfer with counter+1 < length) sets err_len, and RUN exits to DRAIN immediately.
REQ-028 s_last low on the final counted beat sets err_len; the run still completes normally.
REQ-029 DRAIN lasts until the pipeline valid bits are empty, then moves to DONE; done rises exactly 3 cycles after the final transfer.
REQ-030 sad_result is driven from the accumulator register and is valid whenever done=1.

Reset
REQ-031 ARESETN low asynchronously forces:
- IDLE;
- s_ready=0, busy=0, done=0, err_len=0, ovf=0;
- sad_result=0, counter=0, all pipeline valid bits 0.
REQ-032 Reset asserted mid-run discards all in-flight beats with no partial result.
REQ-033 After reset release, the block waits in IDLE for cfg_start.

Verification
REQ-034 Single beat: cfg_len=1, a=0x01020304, b=0x04030201, s_last=1 -> sad_result=8, done 3 cycles after transfer, err_len=0.
REQ-035 Backpressure-free burst: cfg_len=4, each beat a=0xFFFFFFFF, b=0x00000000, s_valid gapped every other cycle -> sad_result=4080, s_ready high throughout RUN.
REQ-036 Length mismatch, both directions:
- cfg_len=4 with s_last on beat 2 -> done with sad_result of 2 beats, err_len=1;
- cfg_len=2 with no s_last -> err_len=1.
REQ-037 Zero length and saturation:
- cfg_len=0 -> done next cycle, sad_result=0;
- with C_ACC_W=12 for the test, cfg_len=5 beats of 1020 -> sad_result=0xFFF, ovf=1.
REQ-038 Reset mid-run: ARESETN low after beat 2 of 4 -> all outputs 0 immediately; a fresh run afterwards gives the correct independent result.
REQ-039 Start while busy: cfg_start pulsed in RUN -> ignored, and the result equals the original run's.
